// File: rtl/sha3_digest_tx.sv
// Streams a captured SHA3 digest (224/256/384/512 bits) as WIDTH-bit words over valid/ready/last.
// Word k is the straight slice D_in[WIDTH*k +: WIDTH] of the state captured on D_valid.
module sha3_digest_tx #(
    parameter int WIDTH   = 16,
    parameter int STATE_W = 1600
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [1:0]         ID,
    input  logic [STATE_W-1:0] D_in,
    input  logic               D_valid,
    output logic               D_ack,
    output logic [WIDTH-1:0]   TDATA,
    output logic               TVALID,
    output logic               TLAST,
    input  logic               TREADY,
    output logic               busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]   state;
    logic [511:0] sreg;
    logic [5:0]   cnt;
    logic [5:0]   n_last;

    // Lanes above the widest digest are never transmitted.
    logic unused_state_hi;
    assign unused_state_hi = ^D_in[STATE_W-1:512];

    function automatic logic [5:0] last_word(input logic [1:0] id);
        int bits;
        case (id)
            2'd0:    bits = 224;
            2'd1:    bits = 256;
            2'd2:    bits = 384;
            default: bits = 512;
        endcase
        return 6'(bits / WIDTH - 1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= ST_IDLE;
            // NOTE: the wide shift register is reset too, so TDATA reads 0 out of reset.
            sreg   <= '0;
            cnt    <= '0;
            n_last <= '0;
        end else if (state == ST_IDLE) begin
            if (D_valid) begin
                sreg   <= D_in[511:0];
                cnt    <= '0;
                n_last <= last_word(ID);
                state  <= ST_SEND;
            end
        end else if (TREADY) begin
            if (cnt == n_last) begin
                state <= ST_IDLE;
            end else begin
                sreg <= sreg >> WIDTH;
                cnt  <= cnt + 6'd1;
            end
        end
    end

    assign busy   = (state == ST_SEND);
    assign TVALID = busy;
    assign D_ack  = (state == ST_IDLE);
    assign TDATA  = sreg[WIDTH-1:0];
    assign TLAST  = busy && (cnt == n_last);

endmodule

// File: tb/tb_sha3_digest_tx.sv
// Scoreboard bench for sha3_digest_tx: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_sha3_digest_tx;

    localparam int W = 16;
    localparam logic [255:0] DIG256 = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    localparam logic [223:0] DIG224 = 224'h6b4e03423667dbb73b6e15454f0eb1abd4597f9a1b078e3f5b5a6bc7;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [1:0]    ID;
    logic [1599:0] D_in;
    logic          D_valid;
    logic          D_ack;
    logic [W-1:0]  TDATA;
    logic          TVALID;
    logic          TLAST;
    logic          TREADY;
    logic          busy;

    sha3_digest_tx #(.WIDTH(W), .STATE_W(1600)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ID(ID), .D_in(D_in), .D_valid(D_valid),
        .D_ack(D_ack), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST),
        .TREADY(TREADY), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] rx_q[$];
    int           n_vec = 0;
    int           n_fail = 0;
    int           hs_total = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // Digest given MSB-first (byte 0 in the top byte); byte i lands at D_in[8i +: 8].
    function automatic logic [1599:0] digest_state(input logic [511:0] dig, input int nbytes);
        logic [1599:0] s;
        s = rand_state();
        for (int i = 0; i < nbytes; i++) s[8*i +: 8] = dig[8*(nbytes-1-i) +: 8];
        return s;
    endfunction

    function automatic int words_for(input logic [1:0] id);
        case (id)
            2'd0:    return 224 / W;
            2'd1:    return 256 / W;
            2'd2:    return 384 / W;
            default: return 512 / W;
        endcase
    endfunction

    task automatic push_burst(input logic [1599:0] s, input logic [1:0] id);
        exp_t e;
        int   n;
        n = words_for(id);
        for (int k = 0; k < n; k++) begin
            e.data = s[W*k +: W];
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_state(input logic [1:0] id, input logic [1599:0] s);
        int c;
        c = 0;
        while (!D_ack && c < 50) begin
            tick();
            c++;
        end
        if (!D_ack) check("d_ack_wait_timeout", 64'd0, 64'd1);
        push_burst(s, id);
        ID      = id;
        D_in    = s;
        D_valid = 1'b1;
        tick();
        D_valid = 1'b0;
    endtask

    task automatic run_burst(input bit rnd, input int poke_at);
        bit last_hs;
        bit done;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (rnd) TREADY = 1'($urandom_range(0, 1));
            if (cyc == poke_at) begin
                D_valid = 1'b1;
                ID      = 2'd0;
                D_in    = ~D_in;
            end else if (cyc == poke_at + 1) begin
                D_valid = 1'b0;
            end
            if (TVALID) begin
                check("d_ack_in_burst", 64'(D_ack), 64'd0);
                check("busy_in_burst", 64'(busy), 64'd1);
            end
            last_hs = TVALID && TREADY && TLAST;
            tick();
            if (last_hs) begin
                check("d_ack_after_last", 64'(D_ack), 64'd1);
                check("tvalid_after_last", 64'(TVALID), 64'd0);
                check("tlast_after_last", 64'(TLAST), 64'd0);
                done = 1'b1;
            end
        end
        if (!done) check("burst_timeout", 64'd0, 64'd1);
        TREADY = 1'b1;
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every handshake pops one expected word; stalled cycles must hold the word.
    always @(negedge ACLK) begin
        exp_t e;
        if (!ARESET && TVALID && TREADY) begin
            hs_total++;
            rx_q.push_back(TDATA);
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(TDATA), 64'hdead);
            end else begin
                e = sb.pop_front();
                check("tdata", 64'(TDATA), 64'(e.data));
                check("tlast", 64'(TLAST), 64'(e.last));
            end
        end
        if (!ARESET && stall_prev) begin
            check("stall_tvalid", 64'(TVALID), 64'd1);
            check("stall_tdata", 64'(TDATA), 64'(prev_data));
            check("stall_tlast", 64'(TLAST), 64'(prev_last));
        end
        stall_prev = !ARESET && TVALID && !TREADY;
        prev_data  = TDATA;
        prev_last  = TLAST;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1599:0] sa;
        logic [1599:0] sb_state;
        logic [255:0]  got;
        int            hs0;

        ARESET = 1'b1; TREADY = 1'b0; D_valid = 1'b0; ID = 2'd0; D_in = '0;
        repeat (3) tick();
        ARESET = 1'b0;
        tick();
        check("rst_tvalid", 64'(TVALID), 64'd0);
        check("rst_tlast", 64'(TLAST), 64'd0);
        check("rst_tdata", 64'(TDATA), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_d_ack", 64'(D_ack), 64'd1);
        TREADY = 1'b1;
        repeat (2) tick();
        check("idle_tready_tvalid", 64'(TVALID), 64'd0);
        check("idle_tready_tdata", 64'(TDATA), 64'd0);

        // SHA3-256 of the empty message
        rx_q.delete();
        send_state(2'd1, digest_state(512'(DIG256), 32));
        run_burst(1'b0, -10);
        check("sha256_words", 64'(rx_q.size()), 64'd16);
        if (rx_q.size() == 16) begin
            check("sha256_w0", 64'(rx_q[0]), 64'hffa7);
            check("sha256_w1", 64'(rx_q[1]), 64'hf8c6);
            check("sha256_w15", 64'(rx_q[15]), 64'h4a43);
            for (int k = 0; k < 16; k++) begin
                got[255-16*k -: 8] = rx_q[k][7:0];
                got[247-16*k -: 8] = rx_q[k][15:8];
            end
            for (int j = 0; j < 4; j++) check("sha256_reassembled", got[64*j +: 64], DIG256[64*j +: 64]);
        end

        // SHA3-224 of the empty message
        rx_q.delete();
        send_state(2'd0, digest_state(512'(DIG224), 28));
        run_burst(1'b0, -10);
        check("sha224_words", 64'(rx_q.size()), 64'd14);
        if (rx_q.size() == 14) begin
            check("sha224_w0", 64'(rx_q[0]), 64'h4e6b);
            check("sha224_w13", 64'(rx_q[13]), 64'hc76b);
        end

        // SHA3-512 length with random backpressure
        hs0 = hs_total;
        send_state(2'd3, rand_state());
        run_burst(1'b1, -10);
        check("sha512_handshakes", 64'(hs_total - hs0), 64'd32);

        // SHA3-384 with a second D_valid and ID change mid-burst
        hs0 = hs_total;
        send_state(2'd2, rand_state());
        run_burst(1'b0, 5);
        check("sha384_handshakes", 64'(hs_total - hs0), 64'd24);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("sha384_no_recapture", 64'(TVALID), 64'd0);
        end

        // Reset mid-burst at word 7, with D_valid raised in the reset cycle
        hs0 = hs_total;
        send_state(2'd1, rand_state());
        repeat (7) tick();
        check("pre_reset_word7_valid", 64'(TVALID), 64'd1);
        ARESET  = 1'b1;
        D_valid = 1'b1;
        tick();
        check("reset_tvalid", 64'(TVALID), 64'd0);
        check("reset_tlast", 64'(TLAST), 64'd0);
        check("reset_d_ack", 64'(D_ack), 64'd1);
        tick();
        check("reset_dvalid_ignored", 64'(TVALID), 64'd0);
        check("reset_words_before", 64'(hs_total - hs0), 64'd7);
        D_valid = 1'b0;
        ARESET  = 1'b0;
        sb.delete();
        tick();
        check("post_reset_idle", 64'(TVALID), 64'd0);
        rx_q.delete();
        sa = digest_state(512'(DIG256), 32);
        send_state(2'd1, sa);
        run_burst(1'b0, -10);
        if (rx_q.size() != 0) check("post_reset_w0", 64'(rx_q[0]), 64'hffa7);
        else check("post_reset_words", 64'd0, 64'd16);

        // D_valid held high: back-to-back bursts with one idle cycle
        while (!D_ack) tick();
        sa       = rand_state();
        sb_state = rand_state();
        ID       = 2'd1;
        D_in     = sa;
        D_valid  = 1'b1;
        push_burst(sa, 2'd1);
        tick();
        D_in = sb_state;
        push_burst(sb_state, 2'd1);
        for (int c = 0; c < 33; c++) begin
            check("b2b_tvalid", 64'(TVALID), (c != 16) ? 64'd1 : 64'd0);
            if (c == 16) check("b2b_bubble_d_ack", 64'(D_ack), 64'd1);
            if (c == 17) D_valid = 1'b0;
            tick();
        end
        check("b2b_end_tvalid", 64'(TVALID), 64'd0);
        check("b2b_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
